// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-control block: match states, player and
// serve encodings, default tuning constants.
package pong_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle      = 3'd0;
  localparam state_t StPlay      = 3'd1;
  localparam state_t StPause     = 3'd2;
  localparam state_t StServeWait = 3'd3;
  localparam state_t StGameOver  = 3'd4;

  localparam logic P1        = 1'b0;
  localparam logic P2        = 1'b1;
  localparam logic ServeToP1 = 1'b0;
  localparam logic ServeToP2 = 1'b1;

  localparam int unsigned DefaultWinScore    = 3;
  localparam int unsigned DefaultPauseFrames = 60;
  localparam int unsigned DefaultSpeedupHits = 4;
  localparam int unsigned DefaultMaxSpeed    = 3;

  // Speed level loaded at every serve: hard mode starts one level up.
  function automatic logic [1:0] base_speed(input logic difficulty);
    return {1'b0, difficulty};
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge strobe generator: one-cycle pulse when sig_i goes 0 -> 1.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= 1'b0;
    else      sig_q <= sig_i;
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/match_sequencer.sv
// Pong match flow controller: serve, rally, point pause and game over; owns the
// scores, serve direction and ball speed level fed to the ball controller.
module match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DefaultWinScore,
  parameter int unsigned PAUSE_FRAMES = DefaultPauseFrames,
  parameter int unsigned SPEEDUP_HITS = DefaultSpeedupHits,
  parameter int unsigned MAX_SPEED    = DefaultMaxSpeed
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       mouse_left,
  input  logic       difficulty,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       paddle_hit,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [1:0] speed,
  output logic [1:0] score_p1,
  output logic [1:0] score_p2,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned PauseW = $clog2(PAUSE_FRAMES + 1);
  localparam int unsigned HitW   = $clog2(SPEEDUP_HITS + 1);

  localparam logic [PauseW-1:0] PauseLast = PauseW'(PAUSE_FRAMES);
  localparam logic [HitW-1:0]   HitLast   = HitW'(SPEEDUP_HITS);
  localparam logic [1:0]        WinVal    = 2'(WIN_SCORE);
  localparam logic [1:0]        MaxSpd    = 2'(MAX_SPEED);

  logic frame_tick, click;

  edge_pulse u_vsync_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (vsync_in),
    .pulse_o (frame_tick)
  );

  edge_pulse u_click_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (mouse_left),
    .pulse_o (click)
  );

  state_t            state_q, state_d;
  logic [PauseW-1:0] pause_cnt_q, pause_cnt_d;
  logic [HitW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [1:0]        speed_q, speed_d, score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic              ball_en_q, ball_en_d, ball_rst_q, ball_rst_d;
  logic              serve_dir_q, serve_dir_d, game_over_q, game_over_d, winner_q, winner_d;

  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    speed_d     = speed_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    ball_rst_d  = 1'b0;

    unique case (state_q)
      StIdle, StServeWait: begin
        if (click) begin
          speed_d    = base_speed(difficulty);
          hit_cnt_d  = '0;
          ball_rst_d = 1'b1;
          state_d    = StPlay;
        end
      end
      StPlay: begin
        // p1_point wins a tie; a paddle_hit alongside any point is dropped.
        if (p1_point || p2_point) begin
          if (p1_point) begin
            if (score_p1_q != WinVal) score_p1_d = score_p1_q + 2'd1;
            serve_dir_d = ServeToP1;
          end else begin
            if (score_p2_q != WinVal) score_p2_d = score_p2_q + 2'd1;
            serve_dir_d = ServeToP2;
          end
          if (p1_point ? (score_p1_d == WinVal) : (score_p2_d == WinVal)) begin
            winner_d = p1_point ? P1 : P2;
            state_d  = StGameOver;
          end else begin
            pause_cnt_d = '0;
            state_d     = StPause;
          end
        end else if (paddle_hit) begin
          hit_cnt_d = hit_cnt_q + 1'b1;
          if (hit_cnt_d == HitLast) begin
            hit_cnt_d = '0;
            if (speed_q != MaxSpd) speed_d = speed_q + 2'd1;
          end
        end
      end
      StPause: begin
        if (frame_tick) begin
          pause_cnt_d = pause_cnt_q + 1'b1;
          if (pause_cnt_d == PauseLast) begin
            if (difficulty) begin
              speed_d    = base_speed(difficulty);
              hit_cnt_d  = '0;
              ball_rst_d = 1'b1;
              state_d    = StPlay;
            end else begin
              state_d = StServeWait;
            end
          end
        end
      end
      StGameOver: begin
        if (click) begin
          score_p1_d = '0;
          score_p2_d = '0;
          winner_d   = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Motion only once a full cycle in PLAY has passed, so it trails ball_rst.
    ball_en_d   = (state_q == StPlay) && (state_d == StPlay);
    game_over_d = (state_d == StGameOver);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pause_cnt_q <= '0;
      hit_cnt_q   <= '0;
      speed_q     <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_rst_q  <= 1'b0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      speed_q     <= speed_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_rst_q  <= ball_rst_d;
      ball_en_q   <= ball_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign ball_en   = ball_en_q;
  assign ball_rst  = ball_rst_q;
  assign serve_dir = serve_dir_q;
  assign speed     = speed_q;
  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed scenarios plus a randomized run checked
// against an event-level model of the match rules.
module tb_match_sequencer;

  localparam int Win = 3;
  localparam int PauseFrames = 60;
  localparam int SpeedupHits = 4;
  localparam int MaxSpeed = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync_in = 1'b0, mouse_left = 1'b0, difficulty = 1'b0;
  logic p1_point = 1'b0, p2_point = 1'b0, paddle_hit = 1'b0;
  logic ball_en, ball_rst, serve_dir, game_over, winner;
  logic [1:0] speed, score_p1, score_p2;

  int checks = 0;
  int failures = 0;

  match_sequencer #(
    .WIN_SCORE    (Win),
    .PAUSE_FRAMES (PauseFrames),
    .SPEEDUP_HITS (SpeedupHits),
    .MAX_SPEED    (MaxSpeed)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .mouse_left (mouse_left),
    .difficulty (difficulty),
    .p1_point   (p1_point),
    .p2_point   (p2_point),
    .paddle_hit (paddle_hit),
    .ball_en    (ball_en),
    .ball_rst   (ball_rst),
    .serve_dir  (serve_dir),
    .speed      (speed),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] all_outs();
    return {ball_en, ball_rst, serve_dir, speed, score_p1, score_p2, game_over};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {vsync_in, mouse_left, difficulty, p1_point, p2_point, paddle_hit} = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  // Outputs reflect the click on return; caller checks, then steps.
  task automatic click();
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  // Score one point in PLAY, sit out the pause and serve again (difficulty 0).
  task automatic point_and_serve(input bit who);
    p1_point = !who;
    p2_point = who;
    step();
    {p1_point, p2_point} = 2'b00;
    repeat (PauseFrames) frame();
    click();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if ({all_outs(), winner} !== 11'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b want=0", {all_outs(), winner});
    end
    do_reset();
    checks++;
    if ({all_outs(), winner} !== 11'd0) begin
      failures++;
      $display("FAIL reset_release got=%b want=0", {all_outs(), winner});
    end
  endtask

  task automatic test_serve();
    for (int d = 0; d < 2; d++) begin
      do_reset();
      difficulty = d[0];
      click();
      checks++;
      if ({ball_rst, ball_en} !== 2'b10) begin
        failures++;
        $display("FAIL serve_pulse d=%0d rst,en got=%b want=10", d, {ball_rst, ball_en});
      end
      step();
      checks++;
      if ({ball_rst, ball_en, speed} !== {2'b01, 1'b0, d[0]}) begin
        failures++;
        $display("FAIL serve_run d=%0d rst,en,spd got=%b want=%b", d,
                 {ball_rst, ball_en, speed}, {2'b01, 1'b0, d[0]});
      end
    end
  endtask

  task automatic test_point_pause();
    do_reset();
    click();
    step();
    p2_point = 1'b1;
    step();
    p2_point = 1'b0;
    checks++;
    if ({score_p2, serve_dir, ball_en} !== {2'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL p2_point s2,dir,en got=%b want=0110", {score_p2, serve_dir, ball_en});
    end
    repeat (PauseFrames - 1) frame();
    click();
    checks++;
    if (ball_rst !== 1'b0) begin
      failures++;
      $display("FAIL pause_click_59 ball_rst got=%b want=0", ball_rst);
    end
    step();
    frame();
    click();
    checks++;
    if (ball_rst !== 1'b1) begin
      failures++;
      $display("FAIL serve_wait_click ball_rst got=%b want=1", ball_rst);
    end
    step();
    difficulty = 1'b1;
    p1_point = 1'b1;
    step();
    p1_point = 1'b0;
    repeat (PauseFrames - 1) frame();
    checks++;
    if ({ball_rst, ball_en} !== 2'b00) begin
      failures++;
      $display("FAIL auto_serve_early rst,en got=%b want=00", {ball_rst, ball_en});
    end
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    checks++;
    if ({ball_rst, ball_en, speed, serve_dir} !== 5'b10010) begin
      failures++;
      $display("FAIL auto_serve rst,en,spd,dir got=%b want=10010",
               {ball_rst, ball_en, speed, serve_dir});
    end
    step();
    checks++;
    if ({ball_rst, ball_en} !== 2'b01) begin
      failures++;
      $display("FAIL auto_serve_run rst,en got=%b want=01", {ball_rst, ball_en});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    click();
    step();
    {p1_point, p2_point} = 2'b11;
    step();
    {p1_point, p2_point} = 2'b00;
    checks++;
    if ({score_p1, score_p2, serve_dir} !== 5'b01000) begin
      failures++;
      $display("FAIL both_points s1,s2,dir got=%b want=01000", {score_p1, score_p2, serve_dir});
    end
    click();
    checks++;
    if ({ball_rst, ball_en} !== 2'b00) begin
      failures++;
      $display("FAIL pause_click rst,en got=%b want=00", {ball_rst, ball_en});
    end
    step();
    p2_point = 1'b1;
    step();
    p2_point = 1'b0;
    checks++;
    if (score_p2 !== 2'd0) begin
      failures++;
      $display("FAIL pause_point s2 got=%0d want=0", score_p2);
    end
  endtask

  task automatic test_speedup();
    do_reset();
    click();
    step();
    for (int i = 1; i <= 16; i++) begin
      paddle_hit = 1'b1;
      step();
      paddle_hit = 1'b0;
      step();
      if (i == 3 || i == 4 || i == 12 || i == 16) begin
        checks++;
        if (speed !== ((i < 4) ? 2'd0 : (i == 4) ? 2'd1 : 2'd3)) begin
          failures++;
          $display("FAIL speedup hits=%0d speed got=%0d", i, speed);
        end
      end
    end
    point_and_serve(1'b0);
    checks++;
    if ({speed, ball_en} !== 3'b001) begin
      failures++;
      $display("FAIL speed_reload spd,en got=%b want=001", {speed, ball_en});
    end
  endtask

  task automatic test_win_restart();
    do_reset();
    click();
    step();
    point_and_serve(1'b0);
    point_and_serve(1'b0);
    p1_point = 1'b1;
    step();
    p1_point = 1'b0;
    checks++;
    if ({score_p1, game_over, winner, ball_en} !== 5'b11100) begin
      failures++;
      $display("FAIL win s1,go,win,en got=%b want=11100",
               {score_p1, game_over, winner, ball_en});
    end
    {p1_point, p2_point} = 2'b01;
    step();
    {p1_point, p2_point} = 2'b00;
    checks++;
    if ({score_p1, score_p2, game_over} !== 5'b11001) begin
      failures++;
      $display("FAIL over_point s1,s2,go got=%b want=11001", {score_p1, score_p2, game_over});
    end
    click();
    checks++;
    if ({score_p1, score_p2, game_over, winner, ball_rst} !== 7'd0) begin
      failures++;
      $display("FAIL restart s1,s2,go,win,rst got=%b want=0",
               {score_p1, score_p2, game_over, winner, ball_rst});
    end
    step();
    click();
    checks++;
    if (ball_rst !== 1'b1) begin
      failures++;
      $display("FAIL second_click ball_rst got=%b want=1", ball_rst);
    end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    click();
    step();
    point_and_serve(1'b0);
    point_and_serve(1'b0);
    checks++;
    if ({ball_en, score_p1} !== 3'b110) begin
      failures++;
      $display("FAIL pre_async en,s1 got=%b want=110", {ball_en, score_p1});
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({all_outs(), winner} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset got=%b want=0", {all_outs(), winner});
    end
    rst = 1'b1;
    step();
  endtask

  // Event-level model: phase 0 idle, 1 play, 2 pause, 3 serve wait, 4 over.
  task automatic test_random();
    int ph, s1, s2, base, hits, pf, act, who, e_speed;
    bit sdir, win, served, e_en, c, p1, p2, h, f;
    do_reset();
    ph = 0; s1 = 0; s2 = 0; base = 0; hits = 0; pf = 0; sdir = 0; win = 0;
    for (int n = 0; n < 1500; n++) begin
      act = (ph == 2 && $urandom_range(0, 99) < 90) ? 6 : int'($urandom_range(0, 7));
      c = (act == 0);
      p1 = (act == 1 || act == 3 || (act == 5 && $urandom_range(0, 1) == 0));
      p2 = (act == 2 || act == 3 || (act == 5 && !p1));
      h = (act == 4 || act == 5);
      f = (act == 6);
      if (act == 7) difficulty = ~difficulty;
      {mouse_left, p1_point, p2_point, paddle_hit, vsync_in} = {c, p1, p2, h, f};
      step();
      {mouse_left, p1_point, p2_point, paddle_hit, vsync_in} = '0;
      served = 0;
      e_en = (ph == 1);
      case (ph)
        0, 3: if (c) begin base = difficulty; hits = 0; served = 1; ph = 1; end
        1: begin
          if (p1 || p2) begin
            who = p1 ? 0 : 1;
            if (who == 0) s1 = s1 + 1; else s2 = s2 + 1;
            sdir = who[0];
            if ((who == 0 ? s1 : s2) == Win) begin ph = 4; win = who[0]; end
            else begin ph = 2; pf = 0; end
          end else if (h) hits = hits + 1;
        end
        2: if (f) begin
          pf = pf + 1;
          if (pf == PauseFrames) begin
            if (difficulty) begin base = 1; hits = 0; served = 1; ph = 1; end
            else ph = 3;
          end
        end
        default: if (c) begin s1 = 0; s2 = 0; win = 0; ph = 0; end
      endcase
      e_en = e_en && (ph == 1);
      e_speed = base + hits / SpeedupHits;
      if (e_speed > MaxSpeed) e_speed = MaxSpeed;
      checks++;
      if ({ball_en, ball_rst, serve_dir, speed, score_p1, score_p2, game_over, winner} !==
          {e_en, served, sdir, 2'(e_speed), 2'(s1), 2'(s2), ph == 4, win}) begin
        failures++;
        $display("FAIL random n=%0d act=%0d got=%b want=%b", n, act,
                 {ball_en, ball_rst, serve_dir, speed, score_p1, score_p2, game_over, winner},
                 {e_en, served, sdir, 2'(e_speed), 2'(s1), 2'(s2), ph == 4, win});
      end
      step();
      checks++;
      if ({ball_en, ball_rst} !== {ph == 1, 1'b0}) begin
        failures++;
        $display("FAIL random_idle n=%0d en,rst got=%b want=%b", n, {ball_en, ball_rst},
                 {ph == 1, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point_pause();
    test_simultaneous();
    test_speedup();
    test_win_restart();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
